// File: rtl/alu_basic.sv
// alu_basic: one-bit ALU slice with arithmetic and logic modes.
// The result and carry are formed combinationally and then registered,
// so DO/CO reflect the inputs present at the previous rising clock edge.
module alu_basic (
  input  logic       clk,
  input  logic       rst,
  input  logic       opA,
  input  logic       opB,
  input  logic [3:0] S,
  input  logic       M,
  input  logic       Cin,
  output logic       DO,
  output logic       CO
);

  logic       x_term;
  logic       y_term;
  logic [1:0] arith_sum;
  logic       do_next;
  logic       co_next;

  // Form the generate/propagate-style terms X and Y, then either add them
  // with the carry-in (arithmetic) or derive the logic function from them.
  // Every logic-mode function in the table equals ~(X ^ Y), so one shared
  // pair of terms serves both modes; Cin only matters in arithmetic mode.
  always_comb begin
    x_term    = opA | (opB & S[0]) | (~opB & S[1]);
    y_term    = (opA & ~opB & S[2]) | (opA & opB & S[3]);
    arith_sum = {1'b0, x_term} + {1'b0, y_term} + {1'b0, Cin};
    if (M) begin
      do_next = ~(x_term ^ y_term);
      co_next = 1'b0;
    end else begin
      do_next = arith_sum[0];
      co_next = arith_sum[1];
    end
  end

  // Output registers: synchronous reset clears both bits, otherwise capture
  // the freshly computed result every cycle (no handshake).
  always_ff @(posedge clk) begin
    if (rst) begin
      DO <= 1'b0;
      CO <= 1'b0;
    end else begin
      DO <= do_next;
      CO <= co_next;
    end
  end

endmodule

// File: tb/tb_alu_basic.sv
// tb_alu_basic: self-checking bench for alu_basic.
// Inputs change just after a falling edge; results are sampled on the next
// falling edge against a behavioural reference built from the function tables.
module tb_alu_basic;

  logic       clk;
  logic       rst;
  logic       opA;
  logic       opB;
  logic [3:0] S;
  logic       M;
  logic       Cin;
  logic       DO;
  logic       CO;

  int         total_checks;
  int         passed_checks;
  logic [1:0] prev_exp;
  logic       have_prev;

  alu_basic dut (
    .clk (clk),
    .rst (rst),
    .opA (opA),
    .opB (opB),
    .S   (S),
    .M   (M),
    .Cin (Cin),
    .DO  (DO),
    .CO  (CO)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: returns {CO, DO} expected after one rising edge.
  // Logic mode uses the function table directly; arithmetic mode adds the
  // X and Y terms and the carry-in as ordinary integers.
  function automatic logic [1:0] refAlu(input logic r, input logic a, input logic b,
                                         input logic [3:0] s, input logic m, input logic cin);
    int   x;
    int   y;
    int   total;
    logic f;
    f = 1'b0;
    if (r) return 2'b00;
    if (m) begin
      case (s)
        4'h0: f = !a;
        4'h1: f = !(a || b);
        4'h2: f = !a && b;
        4'h3: f = 1'b0;
        4'h4: f = !(a && b);
        4'h5: f = !b;
        4'h6: f = a != b;
        4'h7: f = a && !b;
        4'h8: f = !a || b;
        4'h9: f = a == b;
        4'hA: f = b;
        4'hB: f = a && b;
        4'hC: f = 1'b1;
        4'hD: f = a || !b;
        4'hE: f = a || b;
        default: f = a;
      endcase
      return {1'b0, f};
    end
    x = (a || (b && s[0]) || (!b && s[1])) ? 1 : 0;
    y = ((a && !b && s[2]) || (a && b && s[3])) ? 1 : 0;
    total = x + y + (cin ? 1 : 0);
    return {(total / 2) % 2 == 1, total % 2 == 1};
  endfunction

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [1:0] actual, input logic [1:0] expected);
    total_checks++;
    if (actual === expected) begin
      passed_checks++;
    end else begin
      $display("[TB] FAIL %s: got {CO,DO}=%b, expected %b at %0t", tag, actual, expected, $time);
    end
  endtask

  // Drive one operation. Shortly after the inputs change the outputs must
  // still hold the previous result; after the next rising edge they must
  // show the new one.
  task automatic applyStimulus(input string tag, input logic r, input logic a, input logic b,
                               input logic [3:0] s, input logic m, input logic cin);
    logic [1:0] exp_val;
    rst = r;
    opA = a;
    opB = b;
    S   = s;
    M   = m;
    Cin = cin;
    exp_val = refAlu(r, a, b, s, m, cin);
    #1;
    if (have_prev) checkOutput({tag, "_hold"}, {CO, DO}, prev_exp);
    @(negedge clk);
    checkOutput(tag, {CO, DO}, exp_val);
    prev_exp  = exp_val;
    have_prev = 1'b1;
  endtask

  initial begin
    logic [1:0] sweep_const [16];
    logic [2:0] combo;
    logic [1:0] add_exp;
    total_checks  = 0;
    passed_checks = 0;
    have_prev     = 1'b0;
    prev_exp      = 2'b00;
    rst = 1'b1; opA = 1'b0; opB = 1'b0; S = 4'h0; M = 1'b0; Cin = 1'b0;
    @(negedge clk);

    // Reset held for two edges with inputs that would otherwise give DO=1
    applyStimulus("reset_edge1", 1'b1, 1'b1, 1'b1, 4'hC, 1'b1, 1'b0);
    applyStimulus("reset_edge2", 1'b1, 1'b1, 1'b1, 4'hC, 1'b1, 1'b0);
    applyStimulus("post_reset", 1'b0, 1'b1, 1'b1, 4'hC, 1'b1, 1'b0);
    checkOutput("post_reset_const", {CO, DO}, 2'b01);

    // Mid-cycle reset assertion must not disturb the outputs before the edge
    applyStimulus("reset_sync", 1'b1, 1'b1, 1'b1, 4'hC, 1'b1, 1'b0);
    applyStimulus("arith_after_reset", 1'b0, 1'b1, 1'b1, 4'hF, 1'b0, 1'b1);

    // Arithmetic sweep with A=1, B=0, Cin=1
    for (int k = 0; k < 16; k++) sweep_const[k] = 2'bxx;
    sweep_const[0] = 2'b10;
    sweep_const[3] = 2'b10;
    sweep_const[6] = 2'b11;
    sweep_const[9] = 2'b10;
    for (int k = 0; k < 16; k++) begin
      applyStimulus($sformatf("sweep_s%0d", k), 1'b0, 1'b1, 1'b0, 4'(k), 1'b0, 1'b1);
      if (k == 0 || k == 3 || k == 6 || k == 9)
        checkOutput($sformatf("sweep_const_s%0d", k), {CO, DO}, sweep_const[k]);
    end

    // Logic XNOR with Cin=0
    applyStimulus("xnor_10", 1'b0, 1'b1, 1'b0, 4'h9, 1'b1, 1'b0);
    checkOutput("xnor_10_const", {CO, DO}, 2'b00);
    applyStimulus("xnor_11", 1'b0, 1'b1, 1'b1, 4'h9, 1'b1, 1'b0);
    checkOutput("xnor_11_const", {CO, DO}, 2'b01);

    // Logic XOR with Cin=1, which must be ignored
    applyStimulus("xor_11", 1'b0, 1'b1, 1'b1, 4'h6, 1'b1, 1'b1);
    checkOutput("xor_11_const", {CO, DO}, 2'b00);
    applyStimulus("xor_10", 1'b0, 1'b1, 1'b0, 4'h6, 1'b1, 1'b1);
    checkOutput("xor_10_const", {CO, DO}, 2'b01);
    applyStimulus("xor_01", 1'b0, 1'b0, 1'b1, 4'h6, 1'b1, 1'b1);
    checkOutput("xor_01_const", {CO, DO}, 2'b01);

    // Full-adder code: every operand/carry combination
    for (int k = 0; k < 8; k++) begin
      combo = 3'(k);
      add_exp = 2'(int'(combo[2]) + int'(combo[1]) + int'(combo[0]));
      applyStimulus($sformatf("add_%0d", k), 1'b0, combo[2], combo[1], 4'h9, 1'b0, combo[0]);
      checkOutput($sformatf("add_sum_%0d", k), {CO, DO}, add_exp);
    end

    // Randomised operations with occasional reset
    for (int k = 0; k < 300; k++) begin
      applyStimulus("random", ($urandom_range(0, 15) == 0), 1'($urandom), 1'($urandom),
                    4'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule

// File: doc/alu_basic.md
ALU_BASIC -- requirements
Module: alu_basic

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 opA  input  1  operand A.
REQ-005 opB  input  1  operand B.
REQ-006 S  input  4  function select, S[3:0].
REQ-007 M  input  1  mode: 1 = logic, 0 = arithmetic.
REQ-008 Cin  input  1  carry-in, active-high (1 = add one); used in arithmetic mode only.
REQ-009 DO  output  1  registered result bit.
REQ-010 CO  output  1  registered carry-out, active-high.

Function
REQ-011 The block SHALL compute the result combinationally from opA, opB, S, M and Cin, then register it.
- DO and CO SHALL update on the rising clk edge after the inputs are applied (latency 1 cycle).
- There SHALL be no handshake: a new operation is accepted on every cycle.
REQ-012 Arithmetic mode (M=0) SHALL use two internal terms, X and Y.
- X = opA | (opB & S[0]) | (~opB & S[1])
- Y = (opA & ~opB & S[2]) | (opA & opB & S[3])
REQ-013 In arithmetic mode, sum = X + Y + Cin SHALL be formed as a 2-bit unsigned value, with DO = sum[0] and CO = sum[1].
REQ-014 Per-code arithmetic behaviour (follows from REQ-012/013, shown with Cin=0; Cin=1 adds one):
- 0000 A
- 0001 A|B
- 0010 A|~B
- 0011 all-ones
- 0100 A+(A&~B)
- 0101 (A|B)+(A&~B)
- 0110 A+~B
- 0111 (A&~B)+1-bit-ones
- 1000 A+(A&B)
- 1001 A+B
- 1010 (A|~B)+(A&B)
- 1011 (A&B)+ones
- 1100 A+A
- 1101 (A|B)+A
- 1110 (A|~B)+A
- 1111 A+ones
REQ-015 Logic mode (M=1) SHALL set DO per S as follows:
- 0000 ~A
- 0001 ~(A|B)
- 0010 ~A&B
- 0011 0
- 0100 ~(A&B)
- 0101 ~B
- 0110 A^B
- 0111 A&~B
- 1000 ~A|B
- 1001 ~(A^B)
- 1010 B
- 1011 A&B
- 1100 1
- 1101 A|~B
- 1110 A|B
- 1111 A
REQ-016 In logic mode, CO SHALL be 0 and Cin SHALL be ignored.
REQ-017 If an input is X/Z, the outputs are don't-care for that cycle only; there SHALL be no retained state beyond the output registers.
REQ-018 Input changes between clock edges SHALL NOT affect DO or CO until the next rising edge.

Reset
REQ-019 When rst=1 at a rising clk edge, DO SHALL become 0 and CO SHALL become 0, regardless of the other inputs.
REQ-020 Reset SHALL take priority over any operation in progress; the first result after reset SHALL appear on the first rising edge with rst=0.
REQ-021 Reset SHALL have no asynchronous effect: asserting rst between edges leaves DO and CO unchanged.

Verification
REQ-022 rst=1 for 2 edges, with opA=1, opB=1, M=1, S=1100 -> DO=0 and CO=0 after each edge; with rst=0, the next edge gives DO=1.
REQ-023 M=0, Cin=1, opA=1, opB=0, sweeping S 0000..1111 one code per cycle:
- S=0000 -> DO=0, CO=1
- S=0011 -> DO=0, CO=1
- S=0110 -> DO=1, CO=1
- S=1001 -> DO=0, CO=1
- every code checked against REQ-012/013 one cycle later.
REQ-024 M=1, Cin=0, S=1001 -> opA=1, opB=0 gives DO=0; opA=1, opB=1 gives DO=1; CO=0 throughout.
REQ-025 M=1, Cin=1, S=0110 -> operand pairs (1,1), (1,0), (0,1) give DO = 0, 1, 1 respectively; CO=0.
REQ-026 M=0, S=1001 (add), all 8 combinations of opA/opB/Cin -> {CO,DO} equals opA+opB+Cin, each result appearing exactly one cycle after the inputs are applied.
